// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: frame states, prefix bytes
// and the scan-code to decimal-digit lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Extended codes share numbers with the digit keys but are different keys, so they map to F.
    function automatic logic [3:0] digitLookup(input logic [7:0] code, input logic ext);
        logic [3:0] d;
        d = 4'hF;
        if (!ext) begin
            case (code)
                8'h45:   d = 4'd0;
                8'h16:   d = 4'd1;
                8'h1E:   d = 4'd2;
                8'h26:   d = 4'd3;
                8'h25:   d = 4'd4;
                8'h2E:   d = 4'd5;
                8'h36:   d = 4'd6;
                8'h3D:   d = 4'd7;
                8'h3E:   d = 4'd8;
                8'h46:   d = 4'd9;
                default: d = 4'hF;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the asynchronous PS/2 clock and data lines into the system clock domain
// and flags each falling edge of the keyboard clock.
module ps2_sync_edge (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_ps2Clock,
    input  logic i_ps2Data,
    output logic o_data,
    output logic o_fall
);

    logic r_clkMeta;
    logic r_clkSync;
    logic r_clkPrev;
    logic r_dataMeta;
    logic r_dataSync;

    // Both lines idle high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_clkMeta  <= 1'b1;
            r_clkSync  <= 1'b1;
            r_clkPrev  <= 1'b1;
            r_dataMeta <= 1'b1;
            r_dataSync <= 1'b1;
        end else begin
            r_clkMeta  <= i_ps2Clock;
            r_clkSync  <= r_clkMeta;
            r_clkPrev  <= r_clkSync;
            r_dataMeta <= i_ps2Data;
            r_dataSync <= r_dataMeta;
        end
    end

    assign o_data = r_dataSync;
    assign o_fall = r_clkPrev & ~r_clkSync;

endmodule

// File: rtl/ps2_scan_controller.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into key
// events and holds each event in a valid/ready register.
module ps2_scan_controller
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2Clock,
    input  logic       PS2Data,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_ext,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [3:0] digit,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    frame_state_t r_state;
    frame_state_t w_nextState;

    logic          w_fall;
    logic          w_data;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shift;
    logic          r_parityErr;
    logic [TW-1:0] r_timeoutCnt;
    logic          r_ext;
    logic          r_brk;
    logic [7:0]    r_keyCode;
    logic          r_keyRelease;
    logic          r_keyExt;
    logic          r_keyValid;
    logic          r_frameErr;
    logic          r_overrun;

    logic w_startEdge;
    logic w_shiftEdge;
    logic w_parityEdge;
    logic w_timeoutHit;
    logic w_frameGood;
    logic w_abort;
    logic w_newEvent;

    ps2_sync_edge u_sync (
        .i_clock    (Clock),
        .i_reset    (Reset),
        .i_ps2Clock (PS2Clock),
        .i_ps2Data  (PS2Data),
        .o_data     (w_data),
        .o_fall     (w_fall)
    );

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (w_fall && !w_data) w_nextState = ST_DATA;
            ST_DATA:   if (w_fall && r_bitCnt == 3'd7) w_nextState = ST_PARITY;
            ST_PARITY: if (w_fall) w_nextState = ST_STOP;
            ST_STOP:   if (w_fall) w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
        if (w_timeoutHit) w_nextState = ST_IDLE;
    end

    // An edge in the final timeout cycle still counts, so the edge wins over the timeout.
    always_comb begin
        w_startEdge  = (r_state == ST_IDLE) && w_fall && !w_data;
        w_shiftEdge  = (r_state == ST_DATA) && w_fall;
        w_parityEdge = (r_state == ST_PARITY) && w_fall;
        w_timeoutHit = (r_state != ST_IDLE) && !w_fall && (r_timeoutCnt == TO_LAST);
        w_frameGood  = (r_state == ST_STOP) && w_fall && w_data && !r_parityErr;
        w_abort      = ((r_state == ST_STOP) && w_fall && !(w_data && !r_parityErr)) || w_timeoutHit;
        w_newEvent   = w_frameGood && (r_shift != PREFIX_EXT) && (r_shift != PREFIX_BRK);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_bitCnt     <= '0;
            r_shift      <= '0;
            r_parityErr  <= 1'b0;
            r_timeoutCnt <= '0;
        end else begin
            if (r_state == ST_IDLE || w_fall) r_timeoutCnt <= '0;
            else                              r_timeoutCnt <= r_timeoutCnt + TW'(1);
            if (w_startEdge) begin
                r_bitCnt    <= '0;
                r_parityErr <= 1'b0;
            end
            if (w_shiftEdge) begin
                r_shift  <= {w_data, r_shift[7:1]};
                r_bitCnt <= r_bitCnt + 3'd1;
            end
            if (w_parityEdge) r_parityErr <= ~(^{w_data, r_shift});
        end
    end

    // Prefix flags accumulate until a real key byte consumes them or the frame fails.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (w_abort || w_newEvent) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (w_frameGood) begin
            if (r_shift == PREFIX_EXT) r_ext <= 1'b1;
            if (r_shift == PREFIX_BRK) r_brk <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_keyCode    <= '0;
            r_keyRelease <= 1'b0;
            r_keyExt     <= 1'b0;
            r_keyValid   <= 1'b0;
            r_frameErr   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frameErr <= w_abort;
            if (w_newEvent && (!r_keyValid || key_ready)) begin
                r_keyCode    <= r_shift;
                r_keyRelease <= r_brk;
                r_keyExt     <= r_ext;
                r_keyValid   <= 1'b1;
            end else begin
                if (w_newEvent) r_overrun <= 1'b1;
                if (r_keyValid && key_ready) r_keyValid <= 1'b0;
            end
        end
    end

    assign key_code    = r_keyCode;
    assign key_release = r_keyRelease;
    assign key_ext     = r_keyExt;
    assign key_valid   = r_keyValid;
    assign frame_err   = r_frameErr;
    assign overrun     = r_overrun;
    assign digit       = digitLookup(r_keyCode, r_keyExt);

endmodule

// File: tb/tb_ps2_scan_controller.sv
// Self-checking bench for ps2_scan_controller: directed vector table, multi-cycle
// corner cases, then randomized frames checked against a prefix-folding model.
module tb_ps2_scan_controller;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 8;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       PS2Clock = 1'b1;
    logic       PS2Data = 1'b1;
    logic       key_ready = 1'b1;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_ext;
    logic       key_valid;
    logic [3:0] digit;
    logic       frame_err;
    logic       overrun;

    int testsRun = 0;
    int testsFailed = 0;

    int         evCount = 0;
    int         errCount = 0;
    int         validRun = 0;
    int         lastRun = 0;
    logic [7:0] lastCode = '0;
    logic       lastRel = 1'b0;
    logic       lastExt = 1'b0;
    logic [3:0] lastDigit = '0;

    typedef struct {
        logic [7:0] code;
        bit         parGood;
        bit         stopGood;
        bit         expEv;
        bit         expRel;
        bit         expExt;
        logic [3:0] expDig;
        bit         expErr;
    } vec_t;

    vec_t vecs[12];
    logic [7:0] digitCodes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    ps2_scan_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .PS2Clock    (PS2Clock),
        .PS2Data     (PS2Data),
        .key_code    (key_code),
        .key_release (key_release),
        .key_ext     (key_ext),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .digit       (digit),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 Clock = ~Clock;

    // Observe handshakes, error pulses and how long each event stays valid.
    always @(negedge Clock) begin
        if (key_valid && key_ready) begin
            evCount++;
            lastCode  = key_code;
            lastRel   = key_release;
            lastExt   = key_ext;
            lastDigit = digit;
        end
        if (frame_err) errCount++;
        if (key_valid) validRun++;
        else if (validRun > 0) begin
            lastRun  = validRun;
            validRun = 0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] digitRef(input logic [7:0] code, input bit ext);
        for (int k = 0; k < 10; k++)
            if (digitCodes[k] == code) return ext ? 4'hF : k[3:0];
        return 4'hF;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        PS2Data = b;
        repeat (HALF) @(posedge Clock);
        PS2Clock = 1'b0;
        repeat (HALF) @(posedge Clock);
        PS2Clock = 1'b1;
    endtask

    task automatic sendPartial(input logic [7:0] code, input int nBits);
        sendBit(1'b0);
        for (int i = 0; i < nBits; i++) sendBit(code[i]);
        PS2Data = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input bit parGood, input bit stopGood);
        logic par;
        par = ~(^code);
        if (!parGood) par = ~par;
        sendPartial(code, 8);
        sendBit(par);
        sendBit(stopGood);
        PS2Data = 1'b1;
        repeat (HALF) @(posedge Clock);
    endtask

    task automatic runFrame(input logic [7:0] code, input bit parGood, input bit stopGood,
                            input bit expEv, input bit expRel, input bit expExt,
                            input logic [3:0] expDig, input bit expErr, input bit chkRun);
        int e0;
        int r0;
        e0 = evCount;
        r0 = errCount;
        applyStimulus(code, parGood, stopGood);
        repeat (6) @(posedge Clock);
        #1;
        checkOutput($sformatf("events[%h]", code), evCount - e0, int'(expEv));
        checkOutput($sformatf("frame_err[%h]", code), errCount - r0, int'(expErr));
        if (expEv) begin
            checkOutput("key_code", int'(lastCode), int'(code));
            checkOutput("key_release", int'(lastRel), int'(expRel));
            checkOutput("key_ext", int'(lastExt), int'(expExt));
            checkOutput("digit", int'(lastDigit), int'(expDig));
            if (chkRun) checkOutput("valid_cycles", lastRun, 1);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".key_valid"}, int'(key_valid), 0);
        checkOutput({tag, ".key_code"}, int'(key_code), 0);
        checkOutput({tag, ".key_release"}, int'(key_release), 0);
        checkOutput({tag, ".key_ext"}, int'(key_ext), 0);
        checkOutput({tag, ".digit"}, int'(digit), 15);
        checkOutput({tag, ".frame_err"}, int'(frame_err), 0);
        checkOutput({tag, ".overrun"}, int'(overrun), 0);
    endtask

    initial begin
        int e0;
        int r0;
        bit refExt;
        bit refBrk;

        vecs[0]  = '{8'h16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
        vecs[1]  = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0};
        vecs[2]  = '{8'h1E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0};
        vecs[3]  = '{8'hE0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0};
        vecs[4]  = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0};
        vecs[5]  = '{8'h75, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0};
        vecs[6]  = '{8'h45, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[7]  = '{8'h16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1};
        vecs[8]  = '{8'h26, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0};
        vecs[9]  = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0};
        vecs[10] = '{8'h3D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1};
        vecs[11] = '{8'h3E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0};

        repeat (4) @(posedge Clock);
        #1;
        checkResetValues("reset");
        Reset = 1'b0;
        repeat (4) @(posedge Clock);

        for (int i = 0; i < 12; i++)
            runFrame(vecs[i].code, vecs[i].parGood, vecs[i].stopGood, vecs[i].expEv,
                     vecs[i].expRel, vecs[i].expExt, vecs[i].expDig, vecs[i].expErr, 1'b1);

        // Timeout: a prefix, then a frame that stalls after four data bits.
        applyStimulus(8'hF0, 1'b1, 1'b1);
        r0 = errCount;
        sendPartial(8'h3E, 4);
        repeat (TIMEOUT + 30) @(posedge Clock);
        #1;
        checkOutput("timeout.frame_err", errCount - r0, 1);
        runFrame(8'h3E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1);

        // Back-pressure: second event is dropped and overrun sticks.
        key_ready = 1'b0;
        e0 = evCount;
        applyStimulus(8'h16, 1'b1, 1'b1);
        applyStimulus(8'h1E, 1'b1, 1'b1);
        repeat (4) @(posedge Clock);
        #1;
        checkOutput("hold.key_code", int'(key_code), 8'h16);
        checkOutput("hold.key_valid", int'(key_valid), 1);
        checkOutput("hold.overrun", int'(overrun), 1);
        checkOutput("hold.events", evCount - e0, 0);
        key_ready = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("drain.events", evCount - e0, 1);
        checkOutput("drain.key_code", int'(lastCode), 8'h16);
        checkOutput("drain.key_valid", int'(key_valid), 0);
        checkOutput("drain.overrun", int'(overrun), 1);

        // Reset in the middle of a frame.
        sendPartial(8'h26, 3);
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        checkResetValues("midreset");
        Reset = 1'b0;
        repeat (4) @(posedge Clock);
        runFrame(8'h26, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1);

        // Randomized frames against the prefix-folding model.
        refExt = 1'b0;
        refBrk = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [7:0] code;
            bit parGood;
            bit stopGood;
            kind = $urandom_range(0, 19);
            parGood = (kind != 6 && kind != 7);
            stopGood = (kind != 8);
            if (kind <= 2) code = 8'hE0;
            else if (kind <= 5) code = 8'hF0;
            else if ($urandom_range(0, 1) == 1) code = digitCodes[$urandom_range(0, 9)];
            else code = 8'($urandom_range(0, 255));
            if (!parGood || !stopGood) begin
                runFrame(code, parGood, stopGood, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
                refExt = 1'b0;
                refBrk = 1'b0;
            end else if (code == 8'hE0) begin
                runFrame(code, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
                refExt = 1'b1;
            end else if (code == 8'hF0) begin
                runFrame(code, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
                refBrk = 1'b1;
            end else begin
                runFrame(code, 1'b1, 1'b1, 1'b1, refBrk, refExt, digitRef(code, refExt), 1'b0, 1'b1);
                refExt = 1'b0;
                refBrk = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
